stream_demux4: RTL and testbench



---
 rtl/stream_demux4.sv | 199 +++++++++++++++++++
 tb/tb_stream_demux4.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux4.sv
// One-to-four packet demultiplexer with a small FIFO per output.
// Optional build macro DEMUX_STATS_EN adds the pkt_count port (per-output packet counters).

module stream_demux4_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [N-1:0] i_data,
    input  logic         i_last,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [N-1:0] o_data,
    output logic         o_last
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [N:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count/pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= {i_last, i_data};
        end
    end

    assign {o_last, o_data} = r_mem[r_rd_ptr];

endmodule

module stream_demux4 #(
    parameter int N     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_dest,
    input  logic         in_last,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [N-1:0] out_data0,
    output logic [N-1:0] out_data1,
    output logic [N-1:0] out_data2,
    output logic [N-1:0] out_data3,
    output logic [3:0]   out_last
`ifdef DEMUX_STATS_EN
    ,
    output logic [63:0]  pkt_count
`endif
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0] r_state;
    logic [1:0] r_cur_dest;
    logic [0:0] w_next_state;
    logic [1:0] w_next_dest;

    logic [1:0]   w_route;
    logic         w_accept;
    logic [3:0]   w_push;
    logic [3:0]   w_pop;
    logic [3:0]   w_full;
    logic [3:0]   w_empty;
    logic [N-1:0] w_head_data [4];
    logic [3:0]   w_head_last;

    // Destination comes from the port on a first beat, from the latched value mid-packet.
    assign w_route  = (r_state == ST_LOCKED) ? r_cur_dest : in_dest;
    assign in_ready = ~w_full[w_route];
    assign w_accept = in_valid & in_ready;

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        w_push = '0;
        if (w_accept) begin
            w_push[w_route] = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_dest  = r_cur_dest;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (!in_last) begin
                        w_next_state = ST_LOCKED;
                        w_next_dest  = in_dest;
                    end
                end
                ST_LOCKED: begin
                    if (in_last) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cur_dest <= 2'd0;
        end else begin
            r_state    <= w_next_state;
            r_cur_dest <= w_next_dest;
        end
    end

    assign w_pop = out_valid & out_ready;

    for (genvar g = 0; g < 4; g++) begin : g_out
        stream_demux4_fifo #(
            .N     (N),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[g]),
            .i_data  (in_data),
            .i_last  (in_last),
            .i_pop   (w_pop[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_data  (w_head_data[g]),
            .o_last  (w_head_last[g])
        );
    end

    assign out_valid = ~w_empty;
    assign out_last  = w_head_last;
    assign out_data0 = w_head_data[0];
    assign out_data1 = w_head_data[1];
    assign out_data2 = w_head_data[2];
    assign out_data3 = w_head_data[3];

`ifdef DEMUX_STATS_EN
    logic [15:0] r_pkt_cnt [4];

    // Counts completed packets leaving each output, holding at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_pkt_cnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_pop[i] && w_head_last[i] && (r_pkt_cnt[i] != 16'hFFFF)) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign pkt_count = {r_pkt_cnt[3], r_pkt_cnt[2], r_pkt_cnt[1], r_pkt_cnt[0]};
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Self-checking bench for stream_demux4: queue-based packet model plus directed literal checks.
// Build with DEMUX_STATS_EN defined to also check pkt_count.

module tb_stream_demux4;
    localparam int N     = 8;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic [1:0]   in_dest = '0;
    logic         in_last = 1'b0;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready = 4'hF;
    logic [N-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]   out_last;
`ifdef DEMUX_STATS_EN
    logic [63:0]  pkt_count;
`endif

    stream_demux4 #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_last  (out_last)
`ifdef DEMUX_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    logic [N-1:0] w_out_data [4];
    assign w_out_data[0] = out_data0;
    assign w_out_data[1] = out_data1;
    assign w_out_data[2] = out_data2;
    assign w_out_data[3] = out_data3;

    int n_vec = 0;
    int n_miscomp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscomp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: one queue of {last,data} per output, plus "inside a packet" and its destination.
    logic [N:0]  m_q [4][$];
    bit          m_locked = 1'b0;
    logic [1:0]  m_cur = 2'd0;
    logic [15:0] m_cnt [4] = '{default: 16'd0};

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_q[i].delete();
            m_cnt[i] = 16'd0;
        end
        m_locked = 1'b0;
        m_cur    = 2'd0;
    endtask

    // Runs at the falling edge: compare outputs, then advance the model to what the next edge produces.
    task automatic model_step();
        logic [1:0] route;
        bit         rdy;
        bit         exp_v;
        logic [N:0] head;
        if (reset) begin
            model_reset();
            return;
        end
        route = m_locked ? m_cur : in_dest;
        rdy   = (m_q[route].size() < DEPTH);
        check("in_ready", 64'(in_ready), 64'(rdy));
        for (int i = 0; i < 4; i++) begin
            exp_v = (m_q[i].size() != 0);
            check($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(exp_v));
            if (exp_v) begin
                head = m_q[i][0];
                check($sformatf("out_data%0d", i), 64'(w_out_data[i]), 64'(head[N-1:0]));
                check($sformatf("out_last[%0d]", i), 64'(out_last[i]), 64'(head[N]));
            end
        end
`ifdef DEMUX_STATS_EN
        check("pkt_count", pkt_count, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
`endif
        for (int i = 0; i < 4; i++) begin
            if (m_q[i].size() != 0 && out_ready[i]) begin
                head = m_q[i].pop_front();
                if (head[N] && m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
            end
        end
        if (in_valid && rdy) begin
            m_q[route].push_back({in_last, in_data});
            if (!m_locked && !in_last) begin
                m_locked = 1'b1;
                m_cur    = in_dest;
            end else if (m_locked && in_last) begin
                m_locked = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] d, input logic [1:0] dst,
                         input logic l, input logic [3:0] ordy);
        in_valid  = v;
        in_data   = d;
        in_dest   = dst;
        in_last   = l;
        out_ready = ordy;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 2'd0, 1'b0, 4'hF);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset, then idle
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        check("reset out_valid", 64'(out_valid), 64'(4'b0000));
        check("reset in_ready", 64'(in_ready), 64'(1'b1));
`ifdef DEMUX_STATS_EN
        check("reset pkt_count", pkt_count, 64'd0);
`endif
        idle(2);

        // Single beat to output 2
        drive(1'b1, 8'hA5, 2'd2, 1'b1, 4'hF);
        cycle();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        check("single out_valid", 64'(out_valid), 64'(4'b0100));
        check("single out_data2", 64'(out_data2), 64'(8'hA5));
        check("single out_last2", 64'(out_last[2]), 64'(1'b1));
        idle(2);

        // Three-beat packet: destination latched from beat 1 only
        drive(1'b1, 8'h01, 2'd1, 1'b0, 4'hF);
        cycle();
        check("pkt beat1 out_valid", 64'(out_valid), 64'(4'b0010));
        check("pkt beat1 out_data1", 64'(out_data1), 64'(8'h01));
        check("pkt beat1 out_last1", 64'(out_last[1]), 64'(1'b0));
        drive(1'b1, 8'h02, 2'd3, 1'b0, 4'hF);
        cycle();
        drive(1'b1, 8'h03, 2'd3, 1'b1, 4'hF);
        cycle();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        check("pkt beat3 out_valid", 64'(out_valid), 64'(4'b0010));
        check("pkt beat3 out_data1", 64'(out_data1), 64'(8'h03));
        check("pkt beat3 out_last1", 64'(out_last[1]), 64'(1'b1));
        idle(2);

        // Backpressure on output 0
        drive(1'b1, 8'h11, 2'd0, 1'b1, 4'b1110);
        cycle();
        drive(1'b1, 8'h22, 2'd0, 1'b1, 4'b1110);
        cycle();
        drive(1'b1, 8'h33, 2'd0, 1'b1, 4'b1110);
        #1;
        check("bp full in_ready", 64'(in_ready), 64'(1'b0));
        cycle();
        out_ready = 4'hF;
        #1;
        check("bp pop-same-cycle in_ready", 64'(in_ready), 64'(1'b0));
        cycle();
        check("bp after pop in_ready", 64'(in_ready), 64'(1'b1));
        check("bp head after pop", 64'(out_data0), 64'(8'h22));
        cycle();
        idle(4);

        // Output 0 stalled full while a packet flows to output 3
        drive(1'b1, 8'h44, 2'd0, 1'b1, 4'b1110);
        cycle();
        drive(1'b1, 8'h55, 2'd0, 1'b1, 4'b1110);
        cycle();
        drive(1'b1, 8'h66, 2'd3, 1'b0, 4'b1110);
        #1;
        check("iso beat1 in_ready", 64'(in_ready), 64'(1'b1));
        cycle();
        drive(1'b1, 8'h77, 2'd0, 1'b0, 4'b1110);
        #1;
        check("iso beat2 in_ready", 64'(in_ready), 64'(1'b1));
        cycle();
        drive(1'b1, 8'h88, 2'd0, 1'b1, 4'b1110);
        #1;
        check("iso beat3 in_ready", 64'(in_ready), 64'(1'b1));
        cycle();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 4'b1110);
        check("iso out0 head", 64'(out_data0), 64'(8'h44));
        check("iso out0 valid", 64'(out_valid[0]), 64'(1'b1));
        idle(4);

        // Reset in the middle of a packet to output 1
        drive(1'b1, 8'hA1, 2'd1, 1'b0, 4'b1101);
        cycle();
        drive(1'b1, 8'hA2, 2'd1, 1'b0, 4'b1101);
        cycle();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 4'b1101);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midreset out_valid", 64'(out_valid), 64'(4'b0000));
        drive(1'b1, 8'hB2, 2'd2, 1'b1, 4'hF);
        cycle();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        check("midreset next out_valid", 64'(out_valid), 64'(4'b0100));
        check("midreset next out_data2", 64'(out_data2), 64'(8'hB2));
        idle(2);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 4000; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
                  1'($urandom_range(0, 2) == 0), 4'($urandom));
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

endmodule
